arb_mux_reg: RTL
================

ARB_MUX_REG -- requirements
Module: arb_mux_reg

Interface
- REQ-001: Parameter WIDTH, default 5, data bits per channel.
- REQ-002: Parameter NCH, default 4, number of input channels (legal range 2..16).
- REQ-003: Parameter MODE, default 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
- REQ-004: Clk  input  1  sole clock, all state updates on rising edge.
- REQ-005: Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
- REQ-006: in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- REQ-007: in_valid  input  NCH  per-channel request, bit i = channel i holds valid data.
- REQ-008: in_ready  output  NCH  per-channel accept, bit i high = channel i transfers this cycle.
- REQ-009: out_data  output  WIDTH  registered selected data.
- REQ-010: out_valid  output  1  out_data/out_chan hold a valid word.
- REQ-011: out_ready  input  1  downstream accepts word when high with out_valid.
- REQ-012: out_chan  output  clog2(NCH)  index of channel that produced out_data.

Function
- REQ-013: Input transfer on channel i SHALL occur iff in_valid[i] and in_ready[i] are both high at a rising edge.
- REQ-014: Output transfer SHALL occur iff out_valid and out_ready are both high at a rising edge.
- REQ-015: Load enable SHALL be (!out_valid) or (out_ready); no input is accepted when out_valid=1 and out_ready=0.
- REQ-016: in_ready SHALL be one-hot or zero; at most one bit high per cycle, only for a channel with in_valid high, only when load enable is high.
- REQ-017: in_ready SHALL be combinational from in_valid, out_valid, out_ready and arbiter state; no combinational path from in_data.
- REQ-018: On input transfer from channel k, out_data SHALL take channel k data, out_chan SHALL take k, out_valid SHALL be 1 at the next edge (latency 1 cycle).
- REQ-019: Load enable high with no in_valid bit set SHALL clear out_valid; out_data and out_chan SHALL hold previous values.
- REQ-020: Simultaneous output transfer and input transfer SHALL replace the word with no bubble; sustained throughput one word per cycle.
- REQ-021: out_data, out_chan, out_valid SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-022: MODE 1: grant SHALL go to lowest-index requesting channel; no priority state.
- REQ-023: MODE 0: priority pointer ptr (clog2(NCH) bits) SHALL define highest priority; grant goes to first requesting channel scanning ptr, ptr+1, ... wrapping modulo NCH.
- REQ-024: MODE 0: after input transfer from channel k, ptr SHALL become (k+1) mod NCH; k=NCH-1 wraps ptr to 0; without a transfer ptr SHALL hold.
- REQ-025: MODE 0: with all channels continuously valid, grants SHALL cycle 0,1,...,NCH-1,0 — no channel waits more than NCH-1 transfers.
- REQ-026: A channel deasserting in_valid while not granted SHALL lose no state; arbitration is re-evaluated every cycle.

Reset
- REQ-027: While Reset is high at a rising edge: out_valid=0, out_data=0, out_chan=0, ptr=0; in_ready SHALL be all zero during the reset cycle.
- REQ-028: Reset asserted mid-operation SHALL discard the held word with no output transfer; first cycle after reset deassert behaves as empty with ptr=0.

Verification
- REQ-029: Reset, then in_valid=4'b0100, in_data ch2=5'h15, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=5'h15, out_chan=2.
- REQ-030: MODE 0, in_valid=4'b1111 held, out_ready=1, 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3; one word per cycle, no gaps.
- REQ-031: MODE 1, in_valid=4'b1010 held 3 cycles -> out_chan=1 every cycle; channel 3 never granted.
- REQ-032: out_valid=1 (ch0 word 5'h0A), out_ready=0 for 3 cycles with in_valid=4'b0010 -> in_ready=0, out_data stays 5'h0A; out_ready=1 -> ch1 loaded same cycle, next out_chan=1.
- REQ-033: MODE 0, ptr=3 after ch2 transfer, in_valid=4'b1001 -> ch3 granted, ptr wraps to 0; next grant ch0.
- REQ-034: Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_chan=0, in_ready=0; after deassert, in_valid=4'b1111 -> ch0 granted first.

Source files
------------

// File: rtl/arb_mux_reg.sv
// arb_mux_reg
//   Picks one of NCH valid/ready input channels each cycle and registers the
//   selected word into a single output register that feeds a valid/ready
//   downstream. The register reloads whenever it is empty or being drained,
//   so back-to-back words flow at one per cycle with no bubble.
//
//   MODE 0 : round-robin. ptr names the highest-priority channel; after a
//            transfer from channel k, ptr moves to k+1 (wrapping).
//   MODE 1 : fixed priority, lowest index wins, no priority state.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   in_data    NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   NCH        per-channel request
//   in_ready   NCH        per-channel accept (one-hot or zero)
//   out_data   WIDTH      registered selected word
//   out_valid  1          out_data/out_chan hold a valid word
//   out_ready  1          downstream accept
//   out_chan   clog2(NCH) channel that produced out_data
module arb_mux_reg #(
  parameter int WIDTH = 5,
  parameter int NCH   = 4,
  parameter int MODE  = 0,
  localparam int CW   = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_chan
);

  logic [CW-1:0] ptr;
  logic [CW-1:0] gnt_idx;
  logic          gnt_any;
  logic          load_en;
  logic [CW:0]   scan_sum;
  logic [CW-1:0] scan_idx;

  assign load_en = !out_valid || out_ready;

  // Scan NCH candidates starting at ptr (round-robin) or at 0 (fixed).
  // The wrap uses a compare-and-subtract so a non-power-of-two NCH needs
  // no divider.
  always_comb begin
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int j = 0; j < NCH; j++) begin
      if (MODE == 0) begin
        scan_sum = {1'b0, ptr} + (CW+1)'(j);
        if (scan_sum >= (CW+1)'(NCH)) begin
          scan_sum = scan_sum - (CW+1)'(NCH);
        end
      end else begin
        scan_sum = (CW+1)'(j);
      end
      scan_idx = scan_sum[CW-1:0];
      if (!gnt_any && in_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // Reset gates in_ready so nothing is consumed during a reset cycle.
  always_comb begin
    in_ready = '0;
    if (load_en && gnt_any && !reset) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (gnt_any) begin
        out_valid <= 1'b1;
        out_data  <= in_data[gnt_idx*WIDTH +: WIDTH];
        out_chan  <= gnt_idx;
        if (MODE == 0) begin
          ptr <= (gnt_idx == CW'(NCH-1)) ? '0 : gnt_idx + CW'(1);
        end
      end else begin
        // Register drains; data and channel keep their last values.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
